// File: rtl/flit_send_arbiter.sv
// Packet-atomic round-robin arbiter sharing one send-port flit FIFO among NUM_REQ requesters.
// Flit path is a pure mux; only grant state, rr pointer and statistics are registered.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module flit_send_arbiter_lane #(
  parameter int IDX = 0,
  parameter int IDW = 2
) (
  input  logic [IDW-1:0] i_sel,
  input  logic           i_en,
  input  logic           i_put_ready,
  output logic           o_ready
);
  assign o_ready = i_en & i_put_ready & (i_sel == IDW'(IDX));
endmodule

module flit_send_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FLIT_WIDTH = `FLIT_WIDTH,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] i_req_flit,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [FLIT_WIDTH-1:0]         o_put_flit,
  output logic                          o_put_flit_valid,
  input  logic                          i_put_flit_ready,
  output logic [IDW-1:0]                o_grant_id,
  output logic                          o_locked,
  output logic [31:0]                   o_flit_count,
  output logic [31:0]                   o_pkt_count
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_owner;
  logic [31:0]   r_flit_count;
  logic [31:0]   r_pkt_count;

  logic [NUM_REQ-1:0][FLIT_WIDTH-1:0] w_flits;
  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_sel;
  logic           w_en;
  logic           w_pv;
  logic           w_fire;
  logic           w_last;

  assign w_flits = i_req_flit;

  // Search starts just after the last served requester; modulo keeps non-pow2 sizes wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_sel  = (r_state == LOCKED) ? r_owner : w_win;
  assign w_en   = ~i_rst & ((r_state == LOCKED) | w_found);
  assign w_pv   = w_en & i_req_valid[w_sel];
  assign w_fire = w_pv & i_put_flit_ready;
  assign w_last = i_req_last[w_sel];

  assign o_put_flit       = w_flits[w_sel];
  assign o_put_flit_valid = w_pv;
  assign o_grant_id       = w_en ? w_sel : '0;
  assign o_locked         = (r_state == LOCKED);
  assign o_flit_count     = r_flit_count;
  assign o_pkt_count      = r_pkt_count;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    flit_send_arbiter_lane #(.IDX(g), .IDW(IDW)) u_lane (
      .i_sel       (w_sel),
      .i_en        (w_en),
      .i_put_ready (i_put_flit_ready),
      .o_ready     (o_req_ready[g])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= IDW'(NUM_REQ - 1);
      r_owner      <= '0;
      r_flit_count <= '0;
      r_pkt_count  <= '0;
    end else begin
      if (w_fire) r_flit_count <= r_flit_count + 32'd1;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            if (w_fire && w_last) begin
              r_rr_ptr    <= w_win;
              r_pkt_count <= r_pkt_count + 32'd1;
            end else begin
              // Not accepted yet or multi-flit: freeze the grant until the tail goes out.
              r_state <= LOCKED;
              r_owner <= w_win;
            end
          end
        end
        LOCKED: begin
          if (w_fire && w_last) begin
            r_state     <= IDLE;
            r_rr_ptr    <= r_owner;
            r_pkt_count <= r_pkt_count + 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flit_send_arbiter.sv
// Directed table-driven bench for flit_send_arbiter (NUM_REQ=4) plus a NUM_REQ=3 wrap check.
module tb_flit_send_arbiter;
  localparam int FW = 8;

  logic          clk;
  logic          rst;
  logic [4*FW-1:0] req_flit;
  logic [3:0]    req_valid, req_last, req_ready;
  logic [FW-1:0] put_flit;
  logic          put_valid, put_ready, locked;
  logic [1:0]    grant_id;
  logic [31:0]   flit_count, pkt_count;

  logic [3*FW-1:0] req_flit3;
  logic [2:0]    req_valid3, req_last3, req_ready3;
  logic [FW-1:0] put_flit3;
  logic          put_valid3, put_ready3, locked3;
  logic [1:0]    grant_id3;
  logic [31:0]   flit_count3, pkt_count3;

  flit_send_arbiter #(.NUM_REQ(4), .FLIT_WIDTH(FW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_flit(req_flit), .i_req_valid(req_valid),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_put_flit(put_flit),
    .o_put_flit_valid(put_valid), .i_put_flit_ready(put_ready), .o_grant_id(grant_id),
    .o_locked(locked), .o_flit_count(flit_count), .o_pkt_count(pkt_count));

  flit_send_arbiter #(.NUM_REQ(3), .FLIT_WIDTH(FW)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_req_flit(req_flit3), .i_req_valid(req_valid3),
    .i_req_last(req_last3), .o_req_ready(req_ready3), .o_put_flit(put_flit3),
    .o_put_flit_valid(put_valid3), .i_put_flit_ready(put_ready3), .o_grant_id(grant_id3),
    .o_locked(locked3), .o_flit_count(flit_count3), .o_pkt_count(pkt_count3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] v, l;
    logic       pr;
    logic [3:0] rdy;
    logic       pv;
    logic [1:0] gid;
    logic       lk;
    int         fc, pc;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic pr, logic [3:0] rdy,
                              logic pv, logic [1:0] gid, logic lk, int fc, int pc);
    vec_t t;
    t.v = v; t.l = l; t.pr = pr; t.rdy = rdy; t.pv = pv; t.gid = gid; t.lk = lk;
    t.fc = fc; t.pc = pc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] rdy, input logic pv,
                          input logic [1:0] gid, input logic lk, input int fc, input int pc);
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".valid"}, 32'(put_valid), 32'(pv));
    chk({tag, ".grant"}, 32'(grant_id), 32'(gid));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".flit_count"}, flit_count, 32'(fc));
    chk({tag, ".pkt_count"}, pkt_count, 32'(pc));
    if (pv) chk({tag, ".flit"}, 32'(put_flit), 32'(8'hA0 + 8'(gid)));
  endtask

  initial begin
    req_flit   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_flit3  = {8'hA2, 8'hA1, 8'hA0};
    req_valid3 = '0; req_last3 = '0; put_ready3 = 1'b1;

    // test 1: all valid single-flit packets rotate 0,1,2,3,0
    tbl.push_back(mk(4'b1111, 4'b1111, 1, 4'b0001, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 0, 1, 1));
    tbl.push_back(mk(4'b1111, 4'b1111, 1, 4'b0100, 1, 2, 0, 2, 2));
    tbl.push_back(mk(4'b1111, 4'b1111, 1, 4'b1000, 1, 3, 0, 3, 3));
    tbl.push_back(mk(4'b1111, 4'b1111, 1, 4'b0001, 1, 0, 0, 4, 4));
    // test 2: req1 3-flit packet, req2 waits
    tbl.push_back(mk(4'b0110, 4'b0100, 1, 4'b0010, 1, 1, 0, 5, 5));
    tbl.push_back(mk(4'b0110, 4'b0100, 1, 4'b0010, 1, 1, 1, 6, 5));
    tbl.push_back(mk(4'b0110, 4'b0110, 1, 4'b0010, 1, 1, 1, 7, 5));
    tbl.push_back(mk(4'b0100, 4'b0100, 1, 4'b0100, 1, 2, 0, 8, 6));
    // test 3: backpressure holds grant 0 while req3 arrives
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 4'b0000, 1, 0, 0, 9, 7));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 4'b0000, 1, 0, 1, 9, 7));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 4'b0000, 1, 0, 1, 9, 7));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 4'b0000, 1, 0, 1, 9, 7));
    tbl.push_back(mk(4'b1001, 4'b1001, 0, 4'b0000, 1, 0, 1, 9, 7));
    tbl.push_back(mk(4'b1001, 4'b1001, 1, 4'b0001, 1, 0, 1, 9, 7));
    tbl.push_back(mk(4'b1000, 4'b1000, 1, 4'b1000, 1, 3, 0, 10, 8));
    // test 4: owner req2 bubbles for 5 cycles, req0 must not slip in
    tbl.push_back(mk(4'b0100, 4'b0000, 1, 4'b0100, 1, 2, 0, 11, 9));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(4'b0001, 4'b0001, 1, 4'b0100, 0, 2, 1, 12, 9));
    tbl.push_back(mk(4'b0101, 4'b0101, 1, 4'b0100, 1, 2, 1, 12, 9));
    tbl.push_back(mk(4'b0001, 4'b0001, 1, 4'b0001, 1, 0, 0, 13, 10));
    tbl.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 14, 11));

    // reset with requests pending: outputs forced quiet
    rst = 1'b1; req_valid = 4'b1111; req_last = 4'b1111; put_ready = 1'b1;
    #1;
    chk_outs("reset", 4'b0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      req_valid = tbl[i].v; req_last = tbl[i].l; put_ready = tbl[i].pr;
      #1;
      chk_outs($sformatf("row%0d", i), tbl[i].rdy, tbl[i].pv, tbl[i].gid, tbl[i].lk,
               tbl[i].fc, tbl[i].pc);
      @(negedge clk);
    end

    // test 6: reset in the middle of a 4-flit packet from req1
    req_valid = 4'b0010; req_last = 4'b0000; put_ready = 1'b1;
    #1;
    chk_outs("rst6.f1", 4'b0010, 1, 1, 0, 14, 11);
    @(negedge clk);
    req_valid = 4'b0011;
    #1;
    chk_outs("rst6.f2", 4'b0010, 1, 1, 1, 15, 11);
    rst = 1'b1;
    #1;
    chk_outs("rst6.async", 4'b0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b0011; req_last = 4'b0011;
    #1;
    chk_outs("rst6.after", 4'b0001, 1, 0, 0, 0, 0);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk_outs("rst6.count", 4'b0000, 0, 0, 0, 1, 1);

    // test 5: NUM_REQ=3 pointer wraps 2 -> 0
    @(negedge clk);
    req_valid3 = 3'b111; req_last3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] eg;
      eg = 2'(i % 3);
      #1;
      chk($sformatf("n3.grant%0d", i), 32'(grant_id3), 32'(eg));
      chk($sformatf("n3.ready%0d", i), 32'(req_ready3), 32'(3'b001 << eg));
      chk($sformatf("n3.flit%0d", i), 32'(put_flit3), 32'(8'hA0 + 8'(eg)));
      @(negedge clk);
    end
    req_valid3 = '0;
    #1;
    chk("n3.pkt_count", pkt_count3, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
